rr_encoder_arbiter: RTL and testbench
=====================================

// Module: rr_encoder_arbiter
// PURPOSE
//   Round-robin arbiter sharing one downstream resource among N requesters.
//   Outputs a registered one-hot grant and its binary index. The index is
//   the encoded form of the one-hot grant (gnt[i] -> gnt_idx = i), so the
//   datapath can mux directly on gnt_idx. Sits between requesting agents and
//   the shared resource; one grant outstanding at a time.
// PARAMETERS
//   N        8   number of requesters (power of 2, >=2)
//   IDX_W    3   width of grant index, = log2(N)
//   TIMEOUT  16  max GRANT cycles before forced release (used only with macro)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   N      request vector; requester i holds req[i] high until served
//   done       in   1      pulse from current owner: release grant this cycle
//   gnt        out  N      one-hot grant, registered; all-zero when idle
//   gnt_idx    out  IDX_W  binary index of granted requester; 0 when idle
//   gnt_valid  out  1      high while a grant is held
//   timeout    out  1      one-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//   - Reset (async, rst_n=0): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//     ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops grant immediately.
//   - ptr[IDX_W-1:0]: index with highest priority for next arbitration.
//   - FSM states: IDLE, GRANT.
//   - IDLE: if req!=0, winner = first i with req[i]=1 scanning ptr, ptr+1, ...
//     N-1, 0, ... ptr-1 (mod N). Next edge: gnt[winner]=1, gnt_idx=winner,
//     gnt_valid=1, hold_cnt=0, -> GRANT. Latency req->gnt = 1 cycle.
//     req==0: stay IDLE, outputs zero. done is ignored in IDLE.
//   - GRANT: release when done=1 OR req[gnt_idx]=0 (sampled this cycle).
//     On release, next edge: gnt=0, gnt_idx=0, gnt_valid=0,
//     ptr = (gnt_idx+1) mod N, -> IDLE. done and req-drop in same cycle = one
//     release. Requests from other requesters do not preempt.
//   - Minimum one IDLE cycle between consecutive grants; max rate 1 grant/2 clk.
//   - ptr wraps: gnt_idx=N-1 releases -> ptr=0.
//   - Requester that releases then immediately re-requests gets lowest
//     priority next round (fairness: any waiting requester served within N
//     grants).
//   - gnt, gnt_idx, gnt_valid mutually consistent every cycle; gnt never has
//     more than one bit set.
//   - hold_cnt: IDX-independent counter, width clog2(TIMEOUT)+1, increments each
//     GRANT cycle, saturates at TIMEOUT-1, cleared on entry to GRANT.
// CONFIGURATION
//   RR_ARB_TIMEOUT_EN defined:
//     - in GRANT with hold_cnt==TIMEOUT-1 and no normal release, force release
//       (same effects as release, ptr advances) and pulse timeout=1 for one
//       cycle on the same edge grant drops. Normal release in that cycle
//       takes precedence: no timeout pulse.
//   RR_ARB_TIMEOUT_EN undefined:
//     - no hold_cnt logic; grant held indefinitely until done/req drop;
//       timeout tied to 0.
// TESTING
//   1. Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0; hold 3 clk.
//   2. Single req[5]=1 from IDLE -> next edge gnt=8'h20, gnt_idx=5, valid=1;
//      done pulse -> next edge gnt=0, ptr=6.
//   3. req=8'hFF held, done pulsed each GRANT -> gnt_idx sequence 0,1,...,7,0
//      with one idle cycle between grants (wrap check).
//   4. ptr=6, req=8'h41 -> grant idx 6, then idx 0, then idx 6 (rotation).
//   5. Grant idx 3, drop req[3] and pulse done same cycle -> single release,
//      ptr=4; rst_n=0 mid-grant -> gnt=0 asynchronously, ptr=0.
//   6. RR_ARB_TIMEOUT_EN, TIMEOUT=16: grant idx 2 held, no done -> gnt drops
//      after 16 GRANT cycles, timeout=1 one cycle, ptr=3; without macro grant
//      still held after 100 cycles, timeout=0.

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary grant index.
// Optional forced release after TIMEOUT grant cycles: define RR_ARB_TIMEOUT_EN.
module rr_encoder_arbiter #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               tmo_q, tmo_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               release_w;
    logic               force_w;

    // Scan from ptr upward with wrap; N is a power of two so truncation wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_w = done | ~req[idx_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    // Counter rests at zero in IDLE so it is already cleared on entry to GRANT.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q == IDLE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != CW'(TIMEOUT - 1)) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign force_w = (hold_cnt_q == CW'(TIMEOUT - 1)) & ~release_w;
`else
    assign force_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = GRANT;
                    idx_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                end
            end
            GRANT: begin
                // Done and request drop in the same cycle collapse into one release.
                if (release_w || force_w) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    gnt_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    tmo_d   = force_w;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = idx_q;
        gnt_valid = (state_q == GRANT);
        timeout   = tmo_q;
    end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Bench for rr_encoder_arbiter: abstract owner/pointer model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_encoder_arbiter;

    localparam int N       = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 16;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic             done = 1'b0;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    int passed = 0;
    int total  = 0;

    rr_encoder_arbiter #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    endtask

    // Model: who owns the resource (-1 = nobody), whose turn is next,
    // how long the owner has held it, and whether the last drop was forced.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cnt   <= 0;
            m_to    <= 1'b0;
        end else if (m_owner < 0) begin
            m_to <= 1'b0;
            if (req != '0) begin
                m_owner <= pick(req, m_ptr);
                m_cnt   <= 0;
            end
        end else begin
            if (done || !req[m_owner] || (TO_EN && m_cnt == TIMEOUT - 1)) begin
                m_to    <= !(done || !req[m_owner]);
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % N;
            end else begin
                m_to  <= 1'b0;
                m_cnt <= (m_cnt + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        chk("model_gnt", 32'(gnt), 32'(e_gnt));
        chk("model_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("model_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("model_timeout", 32'(timeout), 32'(m_to));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with everyone requesting
        req   = 8'hFF;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        req   = 8'h00;
        rst_n = 1'b1;
        step();

        // Full rotation with wrap back to 0
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
            chk("rot_valid", 32'(gnt_valid), 32'h1);
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rot_gap", 32'(gnt_valid), 32'h0);
        end
        req = 8'h00;
        step();

        // Single requester 5
        req = 8'h20;
        step();
        chk("single_gnt", 32'(gnt), 32'h20);
        chk("single_idx", 32'(gnt_idx), 32'h5);
        chk("single_valid", 32'(gnt_valid), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
        chk("single_rel", 32'(gnt), 32'h0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("idle_done", 32'(gnt_valid), 32'h0);

        // ptr=6 with requesters 6 and 0
        req = 8'h41;
        step();
        chk("rot41_a", 32'(gnt_idx), 32'h6);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("rot41_gap", 32'(gnt_valid), 32'h0);
        step();
        chk("rot41_b", 32'(gnt_idx), 32'h0);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("rot41_c", 32'(gnt_idx), 32'h6);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;
        step();

        // Simultaneous done and request drop, then ptr=4 check
        req = 8'h08;
        step();
        chk("g3_idx", 32'(gnt_idx), 32'h3);
        req  = 8'h00;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("g3_rel", 32'(gnt_valid), 32'h0);
        req = 8'h19;
        step();
        chk("ptr4_idx", 32'(gnt_idx), 32'h4);
        repeat (2) step();
        chk("nopreempt", 32'(gnt), 32'h10);

        // Asynchronous reset mid-grant
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_valid", 32'(gnt_valid), 32'h0);
        chk("async_idx", 32'(gnt_idx), 32'h0);
        req = 8'hFF;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idx", 32'(gnt_idx), 32'h0);

        // Long hold by requester 2
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h04;
        step();
        chk("hold_idx", 32'(gnt_idx), 32'h2);
`ifdef RR_ARB_TIMEOUT_EN
        repeat (15) step();
        chk("to_still", 32'(gnt_valid), 32'h1);
        step();
        chk("to_drop", 32'(gnt_valid), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        req = 8'h0C;
        step();
        chk("to_ptr3", 32'(gnt_idx), 32'h3);
        chk("to_clear", 32'(timeout), 32'h0);
`else
        repeat (100) step();
        chk("hold_valid", 32'(gnt_valid), 32'h1);
        chk("hold_idx2", 32'(gnt_idx), 32'h2);
        chk("hold_to", 32'(timeout), 32'h0);
`endif
        req  = 8'h00;
        done = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
